// File: rtl/ram_dp_clr.sv
// Simple-dual-port synchronous RAM with per-byte write enables, selectable
// read-during-write behaviour and a sweep engine that zeroes the array.
module ram_dp_clr #(
  parameter int unsigned  DATA_WIDTH = 16,
  parameter int unsigned  ADDR_WIDTH = 4,
  parameter int unsigned  DEPTH      = 16,
  parameter int unsigned  RD_MODE    = 0,
  localparam int unsigned NUM_BYTES  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_enb,
  input  logic [NUM_BYTES-1:0]  wr_be,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_enb,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH:0]   DepthW   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  access;
  logic                  wr_in_range, rd_in_range;
  logic                  wr_ok, collide;
  logic [DATA_WIDTH-1:0] old_word, merged_word, rd_word;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StClear: begin
        if (clr) begin
          clr_cnt_d = '0;
        end else if (clr_cnt_q == LastAddr) begin
          state_d = StReady;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      StReady: begin
        if (clr) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end
      end
    endcase
  end

  // clr wins over any access issued in the same cycle
  assign access      = (state_q == StReady) && !rst && !clr;
  assign wr_in_range = {1'b0, wr_addr} < DepthW;
  assign rd_in_range = {1'b0, rd_addr} < DepthW;
  assign wr_ok       = access && wr_enb && wr_in_range;
  assign collide     = wr_ok && (wr_addr == rd_addr);
  assign old_word    = rd_in_range ? mem[rd_addr] : '0;

  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < int'(NUM_BYTES); i++) begin
      if (wr_be[i]) merged_word[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  assign rd_word = (RD_MODE == 1 && collide) ? merged_word : old_word;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StClear) begin
        mem[clr_cnt_q] <= '0;
      end else if (wr_ok) begin
        for (int i = 0; i < int'(NUM_BYTES); i++) begin
          if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StClear;
      clr_cnt_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      if (state_q == StReady && clr) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else if (access && rd_enb) begin
        rd_data_q  <= rd_word;
        rd_valid_q <= 1'b1;
      end else begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == StClear);

endmodule

// File: tb/tb_ram_dp_clr.sv
// Bench for ram_dp_clr: three instances (read-first, write-first, 12-deep) share
// one stimulus stream and are checked against an array-based reference model.
module tb_ram_dp_clr;

  logic        clk = 1'b0;
  logic        rst, clr, wr_enb, rd_enb;
  logic [1:0]  wr_be;
  logic [3:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;

  logic [15:0] rdd [3];
  logic        rdv [3];
  logic        bsy [3];

  int n_tests = 0;
  int n_fail  = 0;
  int nb [3];

  logic [15:0] mm [3][16];
  int          mleft [3];
  logic [15:0] mrdd [3];
  logic        mrdv [3];

  always #5 clk = ~clk;

  ram_dp_clr #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(16), .RD_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .wr_enb(wr_enb), .wr_be(wr_be), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rdd[0]),
    .rd_valid(rdv[0]), .busy(bsy[0]));
  ram_dp_clr #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(16), .RD_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .wr_enb(wr_enb), .wr_be(wr_be), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rdd[1]),
    .rd_valid(rdv[1]), .busy(bsy[1]));
  ram_dp_clr #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(12), .RD_MODE(0)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .wr_enb(wr_enb), .wr_be(wr_be), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rdd[2]),
    .rd_valid(rdv[2]), .busy(bsy[2]));

  function automatic int dep(int k);
    return (k == 2) ? 12 : 16;
  endfunction

  // Reference: a clear makes the array all-zero and locks the RAM for DEPTH edges.
  task automatic model_step();
    logic [15:0] pre, post;
    for (int k = 0; k < 3; k++) begin
      if (rst || (clr && mleft[k] == 0)) begin
        for (int a = 0; a < 16; a++) mm[k][a] = '0;
        mleft[k] = dep(k);
        mrdv[k]  = 1'b0;
        mrdd[k]  = '0;
      end else if (mleft[k] > 0) begin
        mrdv[k] = 1'b0;
        if (clr) begin
          for (int a = 0; a < 16; a++) mm[k][a] = '0;
          mleft[k] = dep(k);
        end else begin
          mleft[k]--;
        end
      end else begin
        pre = (int'(rd_addr) < dep(k)) ? mm[k][rd_addr] : 16'h0000;
        if (wr_enb && int'(wr_addr) < dep(k)) begin
          for (int b = 0; b < 2; b++)
            if (wr_be[b]) mm[k][wr_addr][8*b +: 8] = wr_data[8*b +: 8];
        end
        post = (int'(rd_addr) < dep(k)) ? mm[k][rd_addr] : 16'h0000;
        if (rd_enb) begin
          mrdv[k] = 1'b1;
          mrdd[k] = (k == 1) ? post : pre;
        end else begin
          mrdv[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_idle();
    clr = 0; wr_enb = 0; rd_enb = 0; wr_be = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_enb = 1; wr_addr = a; wr_data = d; wr_be = be;
    cyc();
    wr_enb = 0; wr_be = '0;
  endtask

  task automatic do_read(input logic [3:0] a);
    rd_enb = 1; rd_addr = a;
    cyc();
    rd_enb = 0;
  endtask

  // Counts sampled busy cycles per instance, starting with the current sample.
  task automatic wait_ready();
    bit any;
    for (int k = 0; k < 3; k++) nb[k] = 0;
    for (int i = 0; i < 40; i++) begin
      any = 0;
      for (int k = 0; k < 3; k++) if (bsy[k]) begin nb[k]++; any = 1; end
      if (!any) break;
      cyc();
    end
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1;
    cyc();
    cyc();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (bsy[k] !== 1'b1 || rdv[k] !== 1'b0 || rdd[k] !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset dut%0d busy/valid/data got %b/%b/%h exp 1/0/0000",
                 k, bsy[k], rdv[k], rdd[k]);
      end
    end
    rst = 0;
    wait_ready();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (nb[k] !== dep(k)) begin
        n_fail++;
        $display("FAIL reset_busy_len dut%0d got %0d exp %0d", k, nb[k], dep(k));
      end
    end
    for (int a = 0; a < 16; a++) begin
      rd_enb = 1; rd_addr = 4'(a);
      cyc();
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (rdv[k] !== 1'b1 || rdd[k] !== 16'h0000) begin
          n_fail++;
          $display("FAIL cleared_read dut%0d addr %0d got %b/%h exp 1/0000", k, a, rdv[k], rdd[k]);
        end
      end
    end
    rd_enb = 0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (rdv[k] !== 1'b0 || rdd[k] !== 16'h0000) begin
        n_fail++;
        $display("FAIL idle_hold dut%0d got %b/%h exp 0/0000", k, rdv[k], rdd[k]);
      end
    end
  endtask

  task automatic test_byte_en();
    do_write(4'd3, 16'hA5C3, 2'b11);
    do_write(4'd3, 16'h0011, 2'b01);
    do_write(4'd3, 16'hFFFF, 2'b00);
    do_read(4'd3);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (rdv[k] !== 1'b1 || rdd[k] !== 16'hA511) begin
        n_fail++;
        $display("FAIL byte_en dut%0d got %b/%h exp 1/a511", k, rdv[k], rdd[k]);
      end
    end
  endtask

  task automatic test_collision();
    logic [15:0] exp;
    do_write(4'd7, 16'h1234, 2'b11);
    wr_enb = 1; wr_addr = 4'd7; wr_data = 16'hBEEF; wr_be = 2'b11;
    rd_enb = 1; rd_addr = 4'd7;
    cyc();
    set_idle();
    for (int k = 0; k < 3; k++) begin
      exp = (k == 1) ? 16'hBEEF : 16'h1234;
      n_tests++;
      if (rdd[k] !== exp) begin
        n_fail++;
        $display("FAIL collision dut%0d got %h exp %h", k, rdd[k], exp);
      end
    end
    do_read(4'd7);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (rdd[k] !== 16'hBEEF) begin
        n_fail++;
        $display("FAIL after_collision dut%0d got %h exp beef", k, rdd[k]);
      end
    end
  endtask

  task automatic test_clear();
    do_write(4'd2, 16'h1357, 2'b11);
    clr = 1; wr_enb = 1; wr_addr = 4'd2; wr_data = 16'h7777; wr_be = 2'b11;
    cyc();
    set_idle();
    wait_ready();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (nb[k] !== dep(k)) begin
        n_fail++;
        $display("FAIL clr_busy_len dut%0d got %0d exp %0d", k, nb[k], dep(k));
      end
    end
    do_read(4'd2);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (rdv[k] !== 1'b1 || rdd[k] !== 16'h0000) begin
        n_fail++;
        $display("FAIL clr_drops_write dut%0d got %b/%h exp 1/0000", k, rdv[k], rdd[k]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    clr = 1;
    cyc();
    clr = 0;
    for (int i = 0; i < 3; i++) begin
      wr_enb = 1; wr_addr = 4'd5; wr_data = 16'hFFFF; wr_be = 2'b11;
      rd_enb = 1; rd_addr = 4'd5;
      cyc();
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (bsy[k] !== 1'b1 || rdv[k] !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_ignore dut%0d busy/valid got %b/%b exp 1/0", k, bsy[k], rdv[k]);
        end
      end
    end
    set_idle();
    wait_ready();
    do_read(4'd5);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (rdv[k] !== 1'b1 || rdd[k] !== 16'h0000) begin
        n_fail++;
        $display("FAIL busy_write_dropped dut%0d got %b/%h exp 1/0000", k, rdv[k], rdd[k]);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    clr = 1;
    cyc();
    clr = 0;
    repeat (8) cyc();
    rst = 1;
    cyc();
    rst = 0;
    wait_ready();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (nb[k] !== dep(k)) begin
        n_fail++;
        $display("FAIL rst_mid_clear dut%0d busy len got %0d exp %0d", k, nb[k], dep(k));
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [15:0] exp;
    do_write(4'd13, 16'h5555, 2'b11);
    do_read(4'd13);
    for (int k = 0; k < 3; k++) begin
      exp = (k == 2) ? 16'h0000 : 16'h5555;
      n_tests++;
      if (rdv[k] !== 1'b1 || rdd[k] !== exp) begin
        n_fail++;
        $display("FAIL addr13 dut%0d got %b/%h exp 1/%h", k, rdv[k], rdd[k], exp);
      end
    end
    do_write(4'd11, 16'h9ABC, 2'b11);
    do_read(4'd11);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (rdv[k] !== 1'b1 || rdd[k] !== 16'h9ABC) begin
        n_fail++;
        $display("FAIL last_addr dut%0d got %b/%h exp 1/9abc", k, rdv[k], rdd[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 149) == 0);
      clr     = ($urandom_range(0, 79) == 0);
      wr_enb  = 1'($urandom);
      wr_be   = 2'($urandom);
      wr_addr = 4'($urandom);
      wr_data = 16'($urandom);
      rd_enb  = 1'($urandom);
      rd_addr = ($urandom_range(0, 2) == 0) ? wr_addr : 4'($urandom);
      cyc();
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (bsy[k] !== (mleft[k] > 0) || rdv[k] !== mrdv[k] || rdd[k] !== mrdd[k]) begin
          n_fail++;
          $display("FAIL random cyc %0d dut%0d busy/valid/data got %b/%b/%h exp %b/%b/%h",
                   i, k, bsy[k], rdv[k], rdd[k], mleft[k] > 0, mrdv[k], mrdd[k]);
        end
      end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    rst = 1;
    for (int k = 0; k < 3; k++) begin
      mleft[k] = 0; mrdv[k] = 0; mrdd[k] = '0;
      for (int a = 0; a < 16; a++) mm[k][a] = '0;
    end
    test_reset();
    test_byte_en();
    test_collision();
    test_clear();
    test_busy_ignore();
    test_reset_mid_clear();
    test_out_of_range();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
